// File: rtl/led_matrix_scan_ctrl.sv
// ---------------------------------------------------------------------------
// led_matrix_scan_ctrl
//
// Row-scanning PWM controller for an 8x8 RGB LED matrix. For each row it
// reads the 8 pixels from the pixel store into a local line buffer. It then
// blanks the matrix for BLANK_CYCLES cycles. Finally it drives the row for
// 256 PWM ticks of CLK_DIV cycles each. Rows 0..7 repeat while enable is
// high. enable is only looked at in IDLE and at the end of row 7.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   enable      run request
//   pix_rd      pixel read strobe
//   pix_addr    pixel address {row[2:0], col[2:0]}; holds while pix_rd = 0
//   pix_data    {R, G, B} pixel, valid the cycle after pix_rd
//   row_sel     one-hot row drive, active-high
//   col_r/g/b   column drives, bit c = column c
//   frame_done  one-cycle pulse in the first cycle after row 7 is shown
//   busy        high in every state except IDLE
//
// All outputs are registered. Each output register is loaded from the
// next-state values, so it lines up with the state it belongs to.
// ---------------------------------------------------------------------------
module led_matrix_scan_ctrl #(
    parameter int CLK_DIV      = 16,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        pix_rd,
    output logic [5:0]  pix_addr,
    input  logic [23:0] pix_data,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_r,
    output logic [7:0]  col_g,
    output logic [7:0]  col_b,
    output logic        frame_done,
    output logic        busy
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // step counts FETCH cycles (0..8) and BLANK cycles (0..BLANK_CYCLES-1).
    localparam int STEP_W = (BLANK_CYCLES > 16) ? $clog2(BLANK_CYCLES) : 4;

    typedef enum logic [1:0] {IDLE, FETCH, BLANK, SHOW} state_t;

    state_t             state, state_n;
    logic [2:0]         row, row_n;
    logic [STEP_W-1:0]  step, step_n;
    logic [7:0]         pwm_cnt, pwm_n;
    logic [DIV_W-1:0]   div_cnt, div_n;

    logic               rd_n, fd_n, busy_n;
    logic [5:0]         addr_n;
    logic [7:0]         row_sel_n, col_r_n, col_g_n, col_b_n;

    logic [7:0]         r_buf [8];
    logic [7:0]         g_buf [8];
    logic [7:0]         b_buf [8];

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave one
        // unassigned and infer a latch.
        state_n = state;
        row_n   = row;
        step_n  = step;
        pwm_n   = pwm_cnt;
        div_n   = div_cnt;
        fd_n    = 1'b0;

        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_n = FETCH;
                    row_n   = '0;
                    step_n  = '0;
                end
            end
            FETCH: begin
                // 8 read cycles, then one more cycle to capture the last pixel.
                if (step == STEP_W'(8)) begin
                    state_n = BLANK;
                    step_n  = '0;
                end else begin
                    step_n = step + 1'b1;
                end
            end
            BLANK: begin
                if (step == STEP_W'(BLANK_CYCLES - 1)) begin
                    state_n = SHOW;
                    step_n  = '0;
                    pwm_n   = '0;
                    div_n   = '0;
                end else begin
                    step_n = step + 1'b1;
                end
            end
            SHOW: begin
                if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                    div_n = '0;
                    pwm_n = pwm_cnt + 1'b1;   // wraps 255 -> 0 on the last tick
                    if (pwm_cnt == 8'd255) begin
                        row_n  = row + 1'b1;  // wraps 7 -> 0 at frame end
                        step_n = '0;
                        if (row == 3'd7) begin
                            fd_n    = 1'b1;
                            state_n = enable ? FETCH : IDLE;
                        end else begin
                            state_n = FETCH;
                        end
                    end
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        rd_n      = (state_n == FETCH) && (step_n < STEP_W'(8));
        addr_n    = rd_n ? {row_n, step_n[2:0]} : pix_addr;
        busy_n    = (state_n != IDLE);
        row_sel_n = (state_n == SHOW) ? (8'd1 << row_n) : 8'd0;
        col_r_n   = '0;
        col_g_n   = '0;
        col_b_n   = '0;
        for (int c = 0; c < 8; c++) begin
            col_r_n[c] = (state_n == SHOW) && (pwm_n < r_buf[c]);
            col_g_n[c] = (state_n == SHOW) && (pwm_n < g_buf[c]);
            col_b_n[c] = (state_n == SHOW) && (pwm_n < b_buf[c]);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before the edge.
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            step       <= '0;
            pwm_cnt    <= '0;
            div_cnt    <= '0;
            pix_rd     <= 1'b0;
            pix_addr   <= '0;
            row_sel    <= '0;
            col_r      <= '0;
            col_g      <= '0;
            col_b      <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            row        <= row_n;
            step       <= step_n;
            pwm_cnt    <= pwm_n;
            div_cnt    <= div_n;
            pix_rd     <= rd_n;
            pix_addr   <= addr_n;
            row_sel    <= row_sel_n;
            col_r      <= col_r_n;
            col_g      <= col_g_n;
            col_b      <= col_b_n;
            frame_done <= fd_n;
            busy       <= busy_n;
        end
    end

    // Line buffer. The data for read step k arrives during FETCH step k+1.
    // step 8 truncates to index 0, so subtracting 1 gives entry 7.
    // NOTE: the buffer has no reset. It is always refilled before it is
    // displayed, so a reset would only add logic.
    always_ff @(posedge clk) begin
        if (state == FETCH && step != '0) begin
            r_buf[step[2:0] - 3'd1] <= pix_data[23:16];
            g_buf[step[2:0] - 3'd1] <= pix_data[15:8];
            b_buf[step[2:0] - 3'd1] <= pix_data[7:0];
        end
    end

endmodule

// File: doc/led_matrix_scan_ctrl.md
Name: led_matrix_scan_ctrl

Overview:
Row-scanning PWM display controller for the 8x8 RGB LED matrix.
- Reads the pixel store over a simple read port, one row (8 pixels) at a time, into a local line buffer.
- Blanks the matrix for a fixed interval, then drives one row with 8-bit PWM per colour channel.
- Cycles through rows 0..7 continuously while enabled.
- Sits between the SPI-written pixel store and the matrix row/column drivers.

Parameters:
- CLK_DIV, 16: clk cycles per PWM tick; legal range is 1 and above.
- BLANK_CYCLES, 4: cycles with all rows and columns off before each row is shown; legal range is 1 and above.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  run request; sampled at IDLE and at frame end
- pix_rd  out  1  pixel read strobe
- pix_addr  out  6  pixel address: {row[2:0], col[2:0]}
- pix_data  in  24  {R[23:16], G[15:8], B[7:0]}; valid the cycle after pix_rd
- row_sel  out  8  one-hot row drive, active-high
- col_r  out  8  red column drive, bit c = column c
- col_g  out  8  green column drive, bit c = column c
- col_b  out  8  blue column drive, bit c = column c
- frame_done  out  1  one-cycle pulse after row 7 completes
- busy  out  1  high in every state except IDLE

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - pix_rd = 0, pix_addr = 0, row_sel = 0, col_r/g/b = 0, frame_done = 0, busy = 0.
  - State = IDLE, row counter = 0, pwm_cnt = 0, divider = 0.
  - Line buffer contents are don't-care.
- Reset mid-operation takes effect on the next edge in any state. Operation restarts from row 0.
- States and transitions:
  - IDLE: when enable = 1, go to FETCH with row = 0.
  - FETCH: 9 cycles.
    - Cycles 0..7: pix_rd = 1, pix_addr = {row, col}, col = 0..7.
    - Cycles 1..8: capture pix_data into line buffer entry col-1.
    - Then go to BLANK.
  - BLANK: row_sel = 0 and all columns = 0 for BLANK_CYCLES cycles, then go to SHOW.
  - SHOW: 256*CLK_DIV cycles.
    - row_sel = 1 << row.
    - col_r[c] = (pwm_cnt < R_buf[c]); col_g and col_b are computed the same way from their buffer channels.
    - The first SHOW cycle uses pwm_cnt = 0.
    - pwm_cnt increments when the divider reaches CLK_DIV-1.
    - After the last tick at pwm_cnt = 255: pwm_cnt wraps to 0, row_sel and columns go to 0 next cycle, and row increments.
  - Row 7 end of SHOW:
    - Pulse frame_done for 1 cycle, coinciding with the first cycle after SHOW.
    - row wraps to 0.
    - If enable = 1, go to FETCH; else go to IDLE.
- row_sel and all columns are 0 in FETCH, BLANK and IDLE (no ghosting).
- Only pixels read during FETCH are displayed.
- Duty cycles:
  - Channel value 0 is never on.
  - Value 255 is on 255 of 256 ticks.
  - Value v is on for exactly v*CLK_DIV cycles per row.
- enable deassert mid-frame does not stop the frame. The current frame completes and the block stops only at the frame end.
- pix_rd is never asserted outside FETCH.
- pix_addr holds its last value when pix_rd = 0.
- Row period = 9 + BLANK_CYCLES + 256*CLK_DIV cycles.
- Frame period = 8 × row period.

Test Plan:
1. Reset: hold rst 3 cycles with enable = 1 → all outputs 0, busy = 0. First pix_rd occurs 1 cycle after enable is seen with rst low.
2. CLK_DIV=1, BLANK_CYCLES=4, memory R = 4·addr, G = 255-addr, B = addr; run row 0 →
   - pix_addr 0..7 with pix_rd high 8 consecutive cycles.
   - 4 blank cycles, then row_sel = 0x01 for 256 cycles.
   - col_r[c] high for 4c cycles; col_g[c] high for 255-c cycles; col_b[c] high for c cycles.
3. Boundary values: pixel 0x000000 and 0xFFFFFF in row 2 →
   - Black pixel's columns never high.
   - White pixel's columns high 255 of 256 SHOW cycles, low exactly at pwm_cnt = 255.
4. Frame wrap: enable held high →
   - frame_done is a single-cycle pulse after row 7, every 8×269 cycles.
   - Next pix_addr is 0.
   - With enable low at frame end → IDLE, busy = 0, no further pix_rd.
5. Mid-operation events:
   - enable dropped during row 3 SHOW → rows 4..7 still shown, frame_done pulses, then IDLE.
   - rst asserted mid-SHOW → row_sel = 0 and columns = 0 the next cycle; restart fetch at addr 0.
6. CLK_DIV=4 →
   - pwm_cnt advances every 4 cycles; SHOW lasts 1024 cycles.
   - Value 10 gives exactly 40 high cycles.
   - No row_sel overlap between consecutive rows.
